// File: rtl/mdu_sequencer.sv
// RV32M multiply/divide sequencer for the EX stage.
// Runs a fixed-length multiply or an XLEN-step restoring divide and holds
// the pipeline with STALL until RESULT is ready. RESULT_VALID pulses for one
// cycle in DONE, and the pipeline advances on that edge.
//
// Handshake: an op is accepted on a rising edge where START is high, FLUSH is
// low, ALU_SEL selects an MDU op and the sequencer is IDLE. From that accept
// cycle until the cycle before DONE, STALL is high. RESULT_VALID is high only
// in DONE, for exactly one cycle. RESULT holds its value until the next
// result is written. FLUSH discards any in-flight op.
module mdu_sequencer #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [4:0]      ALU_SEL,
  input  logic [XLEN-1:0] OPERAND1,
  input  logic [XLEN-1:0] OPERAND2,
  input  logic            FLUSH,
  output logic            STALL,
  output logic [XLEN-1:0] RESULT,
  output logic            RESULT_VALID,
  output logic [2:0]      dbg_state
);

  localparam int CNT_MAX = (XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_SIGN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic [1:0]      fn;        // funct3[1:0] of the accepted op
  logic [XLEN-1:0] op_a;      // multiplicand
  logic [XLEN-1:0] op_b;      // multiplier, or divisor magnitude
  logic [XLEN-1:0] rem_q;     // partial remainder
  logic [XLEN-1:0] quo_q;     // dividend shifting out / quotient shifting in
  logic            neg_quo;
  logic            neg_rem;

  // Decode of the incoming instruction.
  logic            is_mdu, accept, in_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  assign is_mdu    = (ALU_SEL[4:3] == 2'b01);
  assign accept    = START & ~FLUSH & is_mdu & (state == S_IDLE);
  assign in_signed = ALU_SEL[2] & ~ALU_SEL[0];
  assign a_neg     = in_signed & OPERAND1[XLEN-1];
  assign b_neg     = in_signed & OPERAND2[XLEN-1];
  assign a_mag     = a_neg ? -OPERAND1 : OPERAND1;
  assign b_mag     = b_neg ? -OPERAND2 : OPERAND2;
  assign div_zero  = (OPERAND2 == '0);
  assign div_ovf   = in_signed & (OPERAND1 == {1'b1, {(XLEN-1){1'b0}}}) &
                     (OPERAND2 == '1);

  // Multiply: sign- or zero-extend by one bit, then a signed product whose
  // low 2*XLEN bits are correct for every mix of operand signedness.
  logic                     a_sext, b_sext;
  logic signed [XLEN:0]     mul_a, mul_b;
  logic signed [2*XLEN-1:0] prod;
  logic [XLEN-1:0]          mul_res;

  assign a_sext  = (fn == 2'b01) | (fn == 2'b10);
  assign b_sext  = (fn == 2'b01);
  assign mul_a   = $signed({a_sext & op_a[XLEN-1], op_a});
  assign mul_b   = $signed({b_sext & op_b[XLEN-1], op_b});
  assign prod    = mul_a * mul_b;
  assign mul_res = (fn == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // One restoring-divide step on {rem, quo}.
  logic [XLEN:0]   rem_sh;
  logic            ge;
  logic [XLEN-1:0] rem_next, quo_next;

  assign rem_sh   = {rem_q, quo_q[XLEN-1]};
  assign ge       = (rem_sh >= {1'b0, op_b});
  assign rem_next = ge ? XLEN'(rem_sh - {1'b0, op_b}) : rem_sh[XLEN-1:0];
  assign quo_next = {quo_q[XLEN-2:0], ge};

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode plus the STALL / RESULT_VALID outputs.
  always_comb begin
    state_nxt    = state;
    STALL        = 1'b0;
    RESULT_VALID = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!ALU_SEL[2])              state_nxt = S_MUL;
          else if (div_zero || div_ovf) state_nxt = S_DONE;
          else                          state_nxt = S_DIV;
        end
      end
      S_MUL:   if (count == '0) state_nxt = S_DONE;
      S_DIV:   if (count == '0) state_nxt = S_SIGN;
      S_SIGN:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (FLUSH) state_nxt = S_IDLE;
    STALL        = ~FLUSH & (accept | (state == S_MUL) | (state == S_DIV) |
                             (state == S_SIGN));
    RESULT_VALID = (state == S_DONE) & ~FLUSH;
  end

  // Operand latch, iteration counter and result register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count   <= '0;
      fn      <= '0;
      op_a    <= '0;
      op_b    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      RESULT  <= '0;
    end else if (!FLUSH) begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            fn      <= ALU_SEL[1:0];
            op_a    <= a_mag;
            op_b    <= b_mag;
            rem_q   <= '0;
            quo_q   <= a_mag;
            neg_quo <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            if (!ALU_SEL[2]) begin
              count <= CW'(MUL_CYCLES - 1);
            end else begin
              count <= CW'(XLEN - 1);
              // Divide-by-zero and signed overflow skip the iterations.
              if (div_zero)     RESULT <= ALU_SEL[1] ? OPERAND1 : '1;
              else if (div_ovf) RESULT <= ALU_SEL[1] ? '0 : OPERAND1;
            end
          end
        end
        S_MUL: begin
          if (count == '0) RESULT <= mul_res;
          else             count  <= count - CW'(1);
        end
        S_DIV: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          if (count != '0) count <= count - CW'(1);
        end
        S_SIGN: begin
          if (fn[1]) RESULT <= neg_rem ? -rem_q : rem_q;
          else       RESULT <= neg_quo ? -quo_q : quo_q;
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Testbench for mdu_sequencer: vector table, random ops against a reference
// model, and hand-written flush / reset / back-to-back sequences.
module tb_mdu_sequencer;

  logic        CLK = 1'b0;
  logic        RESET, START, FLUSH;
  logic [4:0]  ALU_SEL;
  logic [31:0] OPERAND1, OPERAND2;
  logic        STALL, RESULT_VALID;
  logic [31:0] RESULT;
  logic [2:0]  dbg_state;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;

  mdu_sequencer #(.XLEN(32), .MUL_CYCLES(2)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ALU_SEL(ALU_SEL),
    .OPERAND1(OPERAND1), .OPERAND2(OPERAND2), .FLUSH(FLUSH),
    .STALL(STALL), .RESULT(RESULT), .RESULT_VALID(RESULT_VALID),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard.
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        ae, be, p;
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ae  = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
    be  = (f == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    p   = ae * be;
    case (f)
      3'd0:    model = p[31:0];
      3'd1, 3'd2, 3'd3: model = p[63:32];
      3'd4:    model = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5:    model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6:    model = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 3;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Driver: present an op for one accept edge and queue its expectation.
  task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat);
    @(negedge CLK);
    START = 1'b1; ALU_SEL = sel; OPERAND1 = a; OPERAND2 = b;
    #1;
    check("stall_on_accept", {31'b0, STALL}, 32'd1);
    exp_q.push_back(res);
    lat_q.push_back(lat);
    @(posedge CLK);
    #1;
    START = 1'b0; ALU_SEL = 5'b0;
  endtask

  // Monitor: wait (bounded) for RESULT_VALID and compare against the queue head.
  task automatic wait_done();
    int          n;
    bit          seen;
    logic [31:0] er;
    int          el;
    seen = 1'b0;
    for (n = 1; n <= 60; n++) begin
      @(negedge CLK);
      if (RESULT_VALID) begin
        seen = 1'b1;
        break;
      end
      check("stall_busy", {31'b0, STALL}, 32'd1);
    end
    er = exp_q.pop_front();
    el = lat_q.pop_front();
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("result", RESULT, er);
      check("latency", 32'(n), 32'(el));
      check("stall_in_done", {31'b0, STALL}, 32'd0);
    end
  endtask

  // Full op: issue, wait, then check the IDLE cycle after DONE.
  task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat);
    issue(sel, a, b, res, lat);
    wait_done();
    @(negedge CLK);
    check("valid_one_cycle", {31'b0, RESULT_VALID}, 32'd0);
    check("stall_after_done", {31'b0, STALL}, 32'd0);
    check("result_held", RESULT, res);
  endtask

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int valid_seen;

    vecs[0]  = '{5'b01000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 3};  // MUL 7*-3
    vecs[1]  = '{5'b01011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3};  // MULHU
    vecs[2]  = '{5'b01001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 3};  // MULH
    vecs[3]  = '{5'b01010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3};  // MULHSU
    vecs[4]  = '{5'b01100, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, 34}; // DIV -20/3
    vecs[5]  = '{5'b01110, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 34}; // REM -20/3
    vecs[6]  = '{5'b01101, 32'hFFFF_FFEC, 32'd3,         32'h5555_554E, 34}; // DIVU
    vecs[7]  = '{5'b01111, 32'hFFFF_FFEC, 32'd3,         32'd2,         34}; // REMU
    vecs[8]  = '{5'b01101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};  // DIVU /0
    vecs[9]  = '{5'b01111, 32'd5,         32'd0,         32'd5,         1};  // REMU /0
    vecs[10] = '{5'b01100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};  // DIV ovf
    vecs[11] = '{5'b01110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};  // REM ovf
    vecs[12] = '{5'b01100, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFE, 34}; // DIV 7/-3
    vecs[13] = '{5'b01110, 32'd7,         32'hFFFF_FFFD, 32'd1,         34}; // REM 7/-3
    vecs[14] = '{5'b01100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1};  // DIV -5/0
    vecs[15] = '{5'b01000, 32'd6,         32'd7,         32'd42,        3};  // MUL 6*7

    // Reset.
    RESET = 1'b1; START = 1'b0; FLUSH = 1'b0; ALU_SEL = 5'b0;
    OPERAND1 = 32'd0; OPERAND2 = 32'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_result", RESULT, 32'd0);
    check("reset_valid", {31'b0, RESULT_VALID}, 32'd0);
    check("reset_stall", {31'b0, STALL}, 32'd0);
    check("reset_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
    RESET = 1'b0;

    // Vector table.
    for (int i = 0; i < 16; i++)
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

    // Random ops against the model.
    for (int i = 0; i < 10; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      run_op({2'b01, f}, a, b, model(f, a, b), model_lat(f, a, b));
    end

    // Non-MDU ops never stall.
    @(negedge CLK);
    START = 1'b1; ALU_SEL = 5'b00000; OPERAND1 = 32'd3; OPERAND2 = 32'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("add_no_stall", {31'b0, STALL}, 32'd0);
      check("add_no_valid", {31'b0, RESULT_VALID}, 32'd0);
      @(negedge CLK);
    end
    ALU_SEL = 5'b11000;
    #1;
    check("lui_no_stall", {31'b0, STALL}, 32'd0);
    @(negedge CLK);
    check("lui_idle", {29'b0, dbg_state}, {29'b0, ST_IDLE});
    START = 1'b0; ALU_SEL = 5'b01100;
    #1;
    check("no_start_no_stall", {31'b0, STALL}, 32'd0);
    ALU_SEL = 5'b0;

    // FLUSH during DIV iteration 10.
    @(negedge CLK);
    START = 1'b1; ALU_SEL = 5'b01100; OPERAND1 = 32'd100; OPERAND2 = 32'd3;
    @(posedge CLK);
    #1;
    START = 1'b0; ALU_SEL = 5'b0;
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    check("flush_pre_state", {29'b0, dbg_state}, {29'b0, ST_DIV});
    FLUSH = 1'b1;
    #1;
    check("flush_stall", {31'b0, STALL}, 32'd0);
    @(posedge CLK);
    #1;
    FLUSH = 1'b0;
    @(negedge CLK);
    check("flush_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
    check("flush_stall_after", {31'b0, STALL}, 32'd0);
    valid_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (RESULT_VALID) valid_seen++;
      @(negedge CLK);
    end
    check("flush_no_valid", 32'(valid_seen), 32'd0);
    run_op(5'b01000, 32'd6, 32'd7, 32'd42, 3);

    // RESET in the middle of a MUL.
    @(negedge CLK);
    START = 1'b1; ALU_SEL = 5'b01000; OPERAND1 = 32'h0001_2345; OPERAND2 = 32'd3;
    @(posedge CLK);
    #1;
    START = 1'b0; ALU_SEL = 5'b0;
    @(negedge CLK);
    check("mid_mul_state", {29'b0, dbg_state}, {29'b0, ST_MUL});
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_mid_result", RESULT, 32'd0);
    check("rst_mid_valid", {31'b0, RESULT_VALID}, 32'd0);
    check("rst_mid_stall", {31'b0, STALL}, 32'd0);
    check("rst_mid_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
    valid_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (RESULT_VALID) valid_seen++;
      @(negedge CLK);
    end
    check("rst_no_valid", 32'(valid_seen), 32'd0);

    // Back-to-back DIV 42/7 then MUL 6*7; START during DONE is ignored.
    issue(5'b01100, 32'd42, 32'd7, 32'd6, 34);
    wait_done();
    START = 1'b1; ALU_SEL = 5'b01000; OPERAND1 = 32'd6; OPERAND2 = 32'd7;
    #1;
    check("b2b_done_ignores_start", {31'b0, STALL}, 32'd0);
    @(negedge CLK);
    check("b2b_gap_valid", {31'b0, RESULT_VALID}, 32'd0);
    check("b2b_gap_accept", {31'b0, STALL}, 32'd1);
    check("b2b_gap_result", RESULT, 32'd6);
    exp_q.push_back(32'd42);
    lat_q.push_back(3);
    @(posedge CLK);
    #1;
    START = 1'b0; ALU_SEL = 5'b0;
    wait_done();
    @(negedge CLK);
    check("b2b_end_valid", {31'b0, RESULT_VALID}, 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
